// File: rtl/rv_prefetch_unit_pkg.sv
// Shared state encodings and constants for the RV32 prefetch front-end.
// Build option: PREFETCH_MISALIGN_TRAP_EN enables the misaligned-target trap.
package rv_prefetch_unit_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/rv_prefetch_unit_fifo.sv
// Prefetch queue: power-of-two FIFO with registered storage.
// Pointers carry one extra bit so full and empty are distinguishable.
module rv_prefetch_unit_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                     (r_wptr[AW] != r_rptr[AW]);

    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; the count masks stale entries.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_count = CW'(r_wptr - r_rptr);

endmodule

// File: rtl/rv_prefetch_unit.sv
// RV32 fetch front-end: sequential fetch FSM feeding a prefetch queue.
// Build option: PREFETCH_MISALIGN_TRAP_EN halts fetch on misaligned redirects.
module rv_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rd_data,
    input  logic                       imem_ready,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [XLEN-1:0]            instr_data,
    output logic [XLEN-1:0]            instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       fetch_misaligned
);

    import rv_prefetch_unit_pkg::*;

    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              FW       = 2 * XLEN;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_INC   = XLEN'(PC_STEP);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_pc_nxt;
    logic            r_misaligned;
    logic            w_misaligned_nxt;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_bad_target;
    logic            w_busy;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_nxt;
    logic [FW-1:0]   w_head;

`ifdef PREFETCH_MISALIGN_TRAP_EN
    assign w_bad_target = is_misaligned(redirect_pc[1:0]);
    assign w_redir_pc   = redirect_pc;
`else
    assign w_bad_target = 1'b0;
    assign w_redir_pc   = redirect_pc & ~XLEN'(3);
`endif

    // A request still waiting on memory must be drained, not dropped.
    assign w_busy = imem_req && !imem_ready;

    assign w_push = (r_state == S_REQ) && imem_ready && !redirect_valid;
    assign w_pop  = instr_ready && (w_count != '0) && !redirect_valid;

    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_pend_pc_nxt    = r_pend_pc;
        w_misaligned_nxt = r_misaligned;
        if (redirect_valid) begin
            if (w_bad_target) begin
                w_state_nxt      = S_HALT;
                w_misaligned_nxt = 1'b1;
            end else begin
                w_misaligned_nxt = 1'b0;
                if (w_busy) begin
                    w_state_nxt   = S_DRAIN;
                    w_pend_pc_nxt = w_redir_pc;
                end else begin
                    w_state_nxt    = S_REQ;
                    w_fetch_pc_nxt = w_redir_pc;
                end
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_count_nxt < FULL_CNT) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ready) begin
                        w_fetch_pc_nxt = r_fetch_pc + PC_INC;
                        if (w_count_nxt == FULL_CNT) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        w_fetch_pc_nxt = r_pend_pc;
                        w_state_nxt    = S_REQ;
                    end
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_pend_pc    <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    rv_prefetch_unit_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_prefetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({r_fetch_pc, imem_rd_data}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign imem_req         = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr        = r_fetch_pc >> 2;
    assign instr_valid      = (w_count != '0);
    assign instr_pc         = w_head[FW-1:XLEN];
    assign instr_data       = instr_valid ? w_head[XLEN-1:0] : XLEN'(INSTR_NOP);
    assign queue_count      = w_count;
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_rv_prefetch_unit.sv
// Scoreboard bench for rv_prefetch_unit (default DUT plus a RESET_PC near wrap).
// Honours PREFETCH_MISALIGN_TRAP_EN for the misaligned-redirect case.
module tb_rv_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd_data;
    logic        imem_ready;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  queue_count;
    logic        fetch_misaligned;

    logic        imem_req5;
    logic [31:0] imem_addr5;
    logic        instr_valid5;
    logic        instr_ready5;
    logic [31:0] instr_data5;
    logic [31:0] instr_pc5;
    logic [2:0]  queue_count5;
    logic        fetch_misaligned5;

    logic [7:0]  tb_wait;
    logic        mem_en;
    logic [7:0]  r_waitcnt;

    int          checks = 0;
    int          errors = 0;
    int          n_popped = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] beat_log[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] memf(input logic [31:0] w);
        return {w[15:0], ~w[15:0]};
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, memf(pc >> 2)};
    endfunction

    assign imem_ready   = imem_req && mem_en && (r_waitcnt >= tb_wait);
    assign imem_rd_data = memf(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_waitcnt <= '0;
        else if (!imem_req || imem_ready) r_waitcnt <= '0;
        else if (r_waitcnt != 8'hFF) r_waitcnt <= r_waitcnt + 8'd1;
    end

    rv_prefetch_unit u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rd_data     (imem_rd_data),
        .imem_ready       (imem_ready),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .queue_count      (queue_count),
        .fetch_misaligned (fetch_misaligned)
    );

    rv_prefetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut5 (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (1'b0),
        .redirect_pc      (32'h0),
        .imem_req         (imem_req5),
        .imem_addr        (imem_addr5),
        .imem_rd_data     (memf(imem_addr5)),
        .imem_ready       (imem_req5),
        .instr_valid      (instr_valid5),
        .instr_ready      (instr_ready5),
        .instr_data       (instr_data5),
        .instr_pc         (instr_pc5),
        .queue_count      (queue_count5),
        .fetch_misaligned (fetch_misaligned5)
    );

    // Monitor: every consumed head is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop unexpected pc=%h data=%h, none expected",
                         instr_pc, instr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({instr_pc, instr_data} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_pop got pc=%h data=%h exp pc=%h data=%h",
                             instr_pc, instr_data, mon_e[63:32], mon_e[31:0]);
                end
            end
            n_popped++;
        end
        if (rst_n && imem_req && imem_ready) beat_log.push_back(imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (n_popped >= target) break;
            tick();
        end
        checks++;
        if (n_popped < target) begin
            errors++;
            $display("FAIL %s_timeout popped=%0d need=%0d", name, n_popped, target);
        end
        instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        instr_ready5   = 1'b0;
        mem_en         = 1'b1;
        tb_wait        = '0;
        exp_q.delete();
        beat_log.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int tgt;
        int c0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        instr_ready5   = 1'b0;
        mem_en         = 1'b1;
        tb_wait        = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_imem_req", imem_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_queue_count", queue_count, 0);
        check("rst_misaligned", fetch_misaligned, 0);

        // T1: zero-wait memory, core always ready
        do_reset();
        for (int p = 0; p < 8; p++) exp_q.push_back(ent(32'(p * 4)));
        tgt = n_popped + 8;
        instr_ready = 1'b1;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (instr_valid) begin
                lat = k;
                break;
            end
        end
        check("t1_first_valid_by_3", 64'(lat >= 1 && lat <= 3), 64'd1);
        c0 = cyc;
        wait_pops(tgt, 40, "t1");
        check("t1_back_to_back", 64'(cyc - c0), 64'd8);

        // T2: core stalled, queue fills then one pop refetches
        do_reset();
        repeat (8) tick();
        check("t2_count_full", queue_count, 4);
        check("t2_req_low", imem_req, 0);
        check("t2_beats", 64'(beat_log.size()), 64'd4);
        exp_q.push_back(ent(32'h0));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_req_after_pop", imem_req, 1);
        check("t2_addr_after_pop", imem_addr, 32'h4);
        tick();
        check("t2_refilled", queue_count, 4);
        check("t2_req_low_again", imem_req, 0);
        for (int p = 1; p <= 4; p++) exp_q.push_back(ent(32'(p * 4)));
        tgt = n_popped + 4;
        instr_ready = 1'b1;
        wait_pops(tgt, 30, "t2");

        // T3: slow memory, redirect during the first wait cycle
        do_reset();
        tb_wait = 8'd3;
        exp_q.push_back(ent(32'h100));
        exp_q.push_back(ent(32'h104));
        tgt = n_popped + 2;
        instr_ready = 1'b1;
        tick();
        check("t3_req", imem_req, 1);
        check("t3_addr0", imem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("t3_hold_req", imem_req, 1);
        check("t3_hold_addr", imem_addr, 32'h0);
        check("t3_flushed", instr_valid, 0);
        for (int i = 0; i < 20; i++) begin
            if (beat_log.size() >= 2) break;
            tick();
        end
        check("t3_beats_seen", 64'(beat_log.size() >= 2), 64'd1);
        if (beat_log.size() >= 2) begin
            check("t3_drained_addr", beat_log[0], 32'h0);
            check("t3_target_addr", beat_log[1], 32'h40);
        end
        wait_pops(tgt, 60, "t3");

        // T4: redirect with imem_ready and instr_ready in the same cycle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (queue_count == 3'd3) break;
            tick();
        end
        mem_en = 1'b0;
        tick();
        tick();
        check("t4_count3", queue_count, 3);
        check("t4_req_pending", imem_req, 1);
        check("t4_addr_pending", imem_addr, 32'h3);
        mem_en         = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check("t4_empty", queue_count, 0);
        check("t4_valid_low", instr_valid, 0);
        check("t4_new_addr", imem_addr, 32'h20);
        check("t4_new_req", imem_req, 1);
        exp_q.push_back(ent(32'h80));
        exp_q.push_back(ent(32'h84));
        tgt = n_popped + 2;
        instr_ready = 1'b1;
        wait_pops(tgt, 20, "t4");

        // T5: fetch_pc wraps past the top of the address space
        do_reset();
        repeat (8) tick();
        check("t5_count", queue_count5, 4);
        check("t5_pc0", instr_pc5, 32'hFFFF_FFF8);
        check("t5_data0", instr_data5, memf(32'h3FFF_FFFE));
        instr_ready5 = 1'b1;
        tick();
        instr_ready5 = 1'b0;
        check("t5_pc1", instr_pc5, 32'hFFFF_FFFC);
        instr_ready5 = 1'b1;
        tick();
        instr_ready5 = 1'b0;
        check("t5_pc2", instr_pc5, 32'h0);
        check("t5_data2", instr_data5, memf(32'h0));

        // T6: redirect to a misaligned target
        do_reset();
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef PREFETCH_MISALIGN_TRAP_EN
        check("t6_flag_set", fetch_misaligned, 1);
        check("t6_no_req", imem_req, 0);
        repeat (3) tick();
        check("t6_still_no_req", imem_req, 0);
        check("t6_no_valid", instr_valid, 0);
        exp_q.push_back(ent(32'h200));
        exp_q.push_back(ent(32'h204));
        tgt = n_popped + 2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("t6_flag_clear", fetch_misaligned, 0);
        check("t6_resume_req", imem_req, 1);
        check("t6_resume_addr", imem_addr, 32'h80);
`else
        check("t6_flag_tied", fetch_misaligned, 0);
        check("t6_req", imem_req, 1);
        check("t6_aligned_addr", imem_addr, 32'h40);
        exp_q.push_back(ent(32'h100));
        exp_q.push_back(ent(32'h104));
        tgt = n_popped + 2;
`endif
        wait_pops(tgt, 20, "t6");
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
